ad_multi_capture: RTL and testbench
===================================

// Module: ad_multi_capture
// PURPOSE
//  Parametrised N-channel serial ADC front end. It replaces per-channel ad_top instances.
//  - One shared cs_n/sclk pair; N_CH parallel sdata lines, all converted simultaneously.
//  - Programmable sample period, derived from pluse_us.
//  - Per-channel enable mask and overrun detection.
//  - Data goes out as per-channel valid pulses to dsp_top/ast_top, and is also readable on the fx bus.
// PARAMETERS
//  N_CH        8      number of channels, 1..8
//  AD_BITS     16     result width per channel
//  FRAME_BITS  16     sclk cycles per conversion; must be >= AD_BITS
//  DIV         4      clk_sys cycles per sclk half-period, >= 2
//  DEV_ID      6'h10  fx bus device id, matched on addr[21:16]
// PORTS
//  clk_sys   in   1              system clock
//  rst       in   1              asynchronous, active-high reset
//  pluse_us  in   1              1-cycle strobe, once per microsecond
//  cs_n      out  1              shared ADC chip select, active low
//  sclk      out  1              shared ADC serial clock, idles high
//  sdata     in   N_CH           serial data per channel, MSB first
//  ad_data   out  N_CH*AD_BITS   latched results; channel k at [k*AD_BITS +: AD_BITS]
//  ad_vld    out  N_CH           1-cycle pulse per enabled channel when its data updates
//  fx_waddr  in   22             fx write address
//  fx_wr     in   1              fx write strobe
//  fx_data   in   8              fx write data
//  fx_raddr  in   22             fx read address
//  fx_rd     in   1              fx read strobe
//  fx_q      out  8              fx read data
// BEHAVIOUR
//  Reset values:
//  - cs_n=1, sclk=1, ad_data=0, ad_vld=0, fx_q=0.
//  - All registers are 0; FSM is in IDLE.
//  Registers (the byte at addr[7:0] when addr[21:16]==DEV_ID):
//  - 0x00 CTRL, RW:
//    - b0 RUN.
//    - b1 SHOT: self-clearing; starts one conversion.
//    - b2 CLR_OVR: self-clearing; clears OVR.
//  - 0x01 CH_EN, RW: bit k enables channel k; bits >= N_CH read as 0.
//  - 0x02/0x03 PERIOD lo/hi, RW: sample interval in us, 16 bits.
//  - 0x04 STATUS, RO: b0 BUSY (FSM not IDLE/WAIT), b1 OVR.
//  - 0x10+2k/0x11+2k: channel k data lo/hi.
//    - A read of lo snapshots hi into a shadow register.
//    - A read of hi returns the shadow, so lo-then-hi reads are coherent.
//  fx read timing:
//  - fx_q is registered and valid on the cycle after fx_rd.
//  - fx_q=0 when the device id mismatches or the register is unmapped.
//  FSM IDLE -> WAIT -> SETUP -> SHIFT -> HOLD -> DONE:
//  - IDLE: go to SETUP on SHOT, or go to WAIT when RUN=1.
//  - WAIT: count pluse_us up to PERIOD, then go to SETUP. PERIOD=0 means back-to-back conversions.
//  - SETUP: cs_n=0 for one half-period.
//  - SHIFT: sclk toggles every DIV cycles for FRAME_BITS cycles.
//    - Each sdata bit is sampled on the clk_sys cycle in which sclk rises.
//    - The first FRAME_BITS-AD_BITS bits are discarded.
//  - HOLD: cs_n=1 for one half-period.
//  - DONE (1 cycle):
//    - Latch the shift registers into ad_data for enabled channels only.
//    - Pulse ad_vld[k] for those channels. Disabled channels keep their old data.
//    - Next state is WAIT if RUN=1, else IDLE.
//  Sequencing, overrun and edge cases:
//  - The period counter starts at SETUP, so the conversion rate is PERIOD us when PERIOD exceeds the frame time.
//  - Overrun: if the period expires while in SETUP/SHIFT/HOLD, set OVR and drop that tick.
//  - RUN cleared mid-frame: the current frame completes, then the FSM goes to IDLE.
//  - SHOT while busy is ignored.
//  - CLR_OVR coincident with a new overrun: OVR stays set.
//  - CH_EN=0: conversions still run, but no ad_vld is pulsed.
//  - rst at any time: immediate return to reset values; cs_n goes high asynchronously.
// STRUCTURE
//  - Shared package ad_pkg holds:
//    - the FSM state enum;
//    - register offsets: REG_CTRL, REG_CH_EN, REG_PER_L, REG_PER_H, REG_STAT, REG_DATA_BASE;
//    - the fx address field positions.
//  - Sub-module ad_sclk_gen: DIV counter that produces sclk plus rise/half-period strobes.
//  - Top level contains the FSM, N_CH shift registers (generate loop) and the fx register file.
// TESTING
//  1. Reset: assert rst mid-SHIFT -> cs_n=1, sclk=1, ad_vld=0, all registers 0 within the same cycle.
//  2. Single shot:
//     - Stimulus: CH_EN=0xFF, SHOT; each ADC model returns 16'hA5A0+k.
//     - Required: exactly one ad_vld=0xFF pulse; ad_data channel k = 16'hA5A0+k; 16 sclk rising edges while cs_n=0.
//  3. Periodic: PERIOD=50, RUN=1 -> ad_vld pulses exactly 50 us apart for 5 frames; OVR=0.
//  4. Overrun: PERIOD=1, DIV=4 -> OVR=1 and conversions run back-to-back; CLR_OVR then sets OVR again.
//  5. Mask:
//     - Stimulus: CH_EN=0x05, with other channels previously holding data.
//     - Required: only ad_vld[0] and ad_vld[2] pulse; the other channels' data is unchanged.
//  6. fx coherence: read 0x10, the ADC updates, then read 0x11 -> the hi byte matches the old sample; a foreign DEV_ID reads 0.

Source files
------------

// File: rtl/ad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ad_pkg : shared types and register map for the multi-channel ADC     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_CH_EN     = 8'h01;
  localparam logic [7:0] REG_PER_L     = 8'h02;
  localparam logic [7:0] REG_PER_H     = 8'h03;
  localparam logic [7:0] REG_STAT      = 8'h04;
  localparam logic [7:0] REG_DATA_BASE = 8'h10;

  localparam int ADDR_DEV_MSB = 21;
  localparam int ADDR_DEV_LSB = 16;
  localparam int ADDR_REG_MSB = 7;
  localparam int ADDR_REG_LSB = 0;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_SHOT    = 1;
  localparam int CTRL_CLR_OVR = 2;

  function automatic logic [5:0] dev_field(input logic [21:0] addr);
    return addr[ADDR_DEV_MSB:ADDR_DEV_LSB];
  endfunction

  function automatic logic [7:0] reg_field(input logic [21:0] addr);
    return addr[ADDR_REG_MSB:ADDR_REG_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ad_sclk_gen : DIV-cycle half-period timer and idle-high serial clock |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ad_sclk_gen #(
  parameter int DIV = 4
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic run,
  input  logic toggle,
  output logic sclk,
  output logic half,
  output logic rise
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign half = run && (cnt == CW'(DIV - 1));
  // rise marks the cycle whose closing edge drives sclk high
  assign rise = half && toggle && !sclk;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else begin
      cnt <= half ? '0 : cnt + 1'b1;
      if (half && toggle)
        sclk <= ~sclk;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad_multi_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ad_multi_capture : N-channel simultaneous serial ADC capture + fx bus |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ad_multi_capture
  import ad_pkg::*;
#(
  parameter int         N_CH       = 8,
  parameter int         AD_BITS    = 16,
  parameter int         FRAME_BITS = 16,
  parameter int         DIV        = 4,
  parameter logic [5:0] DEV_ID     = 6'h10
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic                    pluse_us,
  output logic                    cs_n,
  output logic                    sclk,
  input  logic [N_CH-1:0]         sdata,
  output logic [N_CH*AD_BITS-1:0] ad_data,
  output logic [N_CH-1:0]         ad_vld,
  input  logic [21:0]             fx_waddr,
  input  logic                    fx_wr,
  input  logic [7:0]              fx_data,
  input  logic [21:0]             fx_raddr,
  input  logic                    fx_rd,
  output logic [7:0]              fx_q
);

  localparam int         BCW     = $clog2(FRAME_BITS + 1);
  localparam logic [7:0] CH_MASK = 8'((9'd1 << N_CH) - 9'd1);

  state_t          state, state_nxt;
  logic            run, ovr;
  logic [7:0]      ch_en;
  logic [15:0]     period, us_cnt;
  logic [BCW-1:0]  bit_cnt;
  logic            gen_run, half, rise, tick, busy;
  logic            wr_hit, rd_hit, shot, clr_ovr;
  logic [7:0]      wr_reg, rd_reg, rd_val;
  logic [15:0]     data16 [N_CH];
  logic [7:0]      shadow_byte [N_CH];
  logic            unused_addr;

  assign unused_addr = ^{fx_waddr[15:8], fx_raddr[15:8]};

  assign wr_hit  = fx_wr && (dev_field(fx_waddr) == DEV_ID);
  assign rd_hit  = dev_field(fx_raddr) == DEV_ID;
  assign wr_reg  = reg_field(fx_waddr);
  assign rd_reg  = reg_field(fx_raddr);
  assign shot    = wr_hit && (wr_reg == REG_CTRL) && fx_data[CTRL_SHOT];
  assign clr_ovr = wr_hit && (wr_reg == REG_CTRL) && fx_data[CTRL_CLR_OVR];

  assign gen_run = state inside {ST_SETUP, ST_SHIFT, ST_HOLD};
  assign busy    = !(state inside {ST_IDLE, ST_WAIT});
  assign tick    = run && pluse_us && (period != 16'd0) &&
                   (({1'b0, us_cnt} + 17'd1) >= {1'b0, period});

  ad_sclk_gen #(.DIV(DIV)) u_sclk (
    .clk_sys (clk_sys),
    .rst     (rst),
    .run     (gen_run),
    .toggle  (state == ST_SHIFT),
    .sclk    (sclk),
    .half    (half),
    .rise    (rise)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (shot) state_nxt = ST_SETUP;
                else if (run) state_nxt = ST_WAIT;
      ST_WAIT:  if (!run) state_nxt = ST_IDLE;
                else if (shot || period == 16'd0 || tick) state_nxt = ST_SETUP;
      ST_SETUP: if (half) state_nxt = ST_SHIFT;
      ST_SHIFT: if (rise && bit_cnt == BCW'(FRAME_BITS - 1)) state_nxt = ST_HOLD;
      ST_HOLD:  if (half) state_nxt = ST_DONE;
      ST_DONE:  if (!run) state_nxt = ST_IDLE;
                else if (period == 16'd0 || tick) state_nxt = ST_SETUP;
                else state_nxt = ST_WAIT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cs_n    <= 1'b1;
      bit_cnt <= '0;
      us_cnt  <= '0;
      ovr     <= 1'b0;
      ad_vld  <= '0;
    end else begin
      state   <= state_nxt;
      cs_n    <= !(state_nxt inside {ST_SETUP, ST_SHIFT});
      bit_cnt <= (state != ST_SHIFT) ? '0 : (rise ? bit_cnt + 1'b1 : bit_cnt);
      // period window is re-armed at each frame start
      if (!run || state == ST_IDLE || (state_nxt == ST_SETUP && state != ST_SETUP))
        us_cnt <= '0;
      else if (pluse_us)
        us_cnt <= tick ? 16'd0 : us_cnt + 16'd1;
      ovr    <= (tick && gen_run) || (ovr && !clr_ovr);
      ad_vld <= (state == ST_DONE) ? ch_en[N_CH-1:0] : '0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      ch_en  <= '0;
      period <= '0;
    end else if (wr_hit) begin
      case (wr_reg)
        REG_CTRL:  run          <= fx_data[CTRL_RUN];
        REG_CH_EN: ch_en        <= fx_data & CH_MASK;
        REG_PER_L: period[7:0]  <= fx_data;
        REG_PER_H: period[15:8] <= fx_data;
        default:   ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (rd_reg)
        REG_CTRL:  rd_val = {7'd0, run};
        REG_CH_EN: rd_val = ch_en;
        REG_PER_L: rd_val = period[7:0];
        REG_PER_H: rd_val = period[15:8];
        REG_STAT:  rd_val = {6'd0, ovr, busy};
        default: begin
          for (int k = 0; k < N_CH; k++) begin
            if (rd_reg == REG_DATA_BASE + 8'(2 * k))
              rd_val = data16[k][7:0];
            else if (rd_reg == REG_DATA_BASE + 8'(2 * k + 1))
              rd_val = shadow_byte[k];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)
      fx_q <= '0;
    else if (fx_rd)
      fx_q <= rd_val;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [AD_BITS-1:0] shreg, data_q;
    logic [7:0]         shadow;

    // leading bits of a longer frame fall off the top of shreg
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        shreg  <= '0;
        data_q <= '0;
        shadow <= '0;
      end else begin
        if (rise)
          shreg <= {shreg[AD_BITS-2:0], sdata[k]};
        if (state == ST_DONE && ch_en[k])
          data_q <= shreg;
        if (fx_rd && rd_hit && rd_reg == REG_DATA_BASE + 8'(2 * k))
          shadow <= data16[k][15:8];
      end
    end

    assign data16[k]                     = 16'(data_q);
    assign shadow_byte[k]                = shadow;
    assign ad_data[k*AD_BITS +: AD_BITS] = data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ad_multi_capture.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_ad_multi_capture : directed self-checking bench for the ADC block |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ad_multi_capture;
  import ad_pkg::*;

  localparam logic [5:0] DEV     = 6'h10;
  localparam logic [5:0] FOREIGN = 6'h11;

  logic         clk_sys = 1'b0;
  logic         rst = 1'b1;
  logic         pluse_us = 1'b0;
  logic         cs_n, sclk;
  logic [7:0]   sdata = '0;
  logic [127:0] ad_data;
  logic [7:0]   ad_vld;
  logic [21:0]  fx_waddr = '0, fx_raddr = '0;
  logic         fx_wr = 1'b0, fx_rd = 1'b0;
  logic [7:0]   fx_data = '0, fx_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int vld_t [256];
  logic [7:0] last_vld = '0;
  int rise_cnt = 0;
  logic prev_sclk = 1'b1, prev_cs = 1'b1;
  int adc_idx = 0;
  logic [15:0] adc_word [8];
  logic [7:0] rq;
  logic [127:0] exp_data;
  int base, rbase;

  ad_multi_capture #(
    .N_CH(8), .AD_BITS(16), .FRAME_BITS(16), .DIV(4), .DEV_ID(DEV)
  ) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .pluse_us (pluse_us),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .sdata    (sdata),
    .ad_data  (ad_data),
    .ad_vld   (ad_vld),
    .fx_waddr (fx_waddr),
    .fx_wr    (fx_wr),
    .fx_data  (fx_data),
    .fx_raddr (fx_raddr),
    .fx_rd    (fx_rd),
    .fx_q     (fx_q)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  initial forever begin
    @(negedge clk_sys);
    pluse_us = (cyc % 100 == 0);
  end

  always @(negedge clk_sys) begin
    if (ad_vld != 8'h00) begin
      if (vld_cnt < 256) vld_t[vld_cnt] = cyc;
      last_vld = ad_vld;
      vld_cnt++;
    end
  end

  always @(negedge clk_sys) begin
    if (sclk && !prev_sclk && !prev_cs) rise_cnt++;
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  // ADC model: MSB shifted out on each falling sclk while selected
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) adc_idx = 0;
    else if (adc_idx < 16) begin
      for (int k = 0; k < 8; k++) sdata[k] = adc_word[k][15 - adc_idx];
      adc_idx++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fx_write(input logic [5:0] dev, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    fx_waddr = {dev, 8'h00, a};
    fx_data  = d;
    fx_wr    = 1'b1;
    @(negedge clk_sys);
    fx_wr    = 1'b0;
  endtask

  task automatic fx_read(input logic [5:0] dev, input logic [7:0] a, output logic [7:0] q);
    @(negedge clk_sys);
    fx_raddr = {dev, 8'h00, a};
    fx_rd    = 1'b1;
    @(negedge clk_sys);
    fx_rd    = 1'b0;
    q        = fx_q;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] q;
    fx_read(DEV, a, q);
    check(tag, q, exp);
  endtask

  task automatic wait_vld(input string tag, input int target, input int maxc);
    int n = 0;
    while (vld_cnt < target && n < maxc) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, vld_cnt >= target, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) adc_word[k] = 16'hA5A0 + 16'(k);

    // power-on reset state
    wait_cycles(3);
    check("por_cs_n", cs_n, 1);
    check("por_sclk", sclk, 1);
    check("por_vld", ad_vld, 0);
    check("por_data", ad_data, 0);
    check("por_fx_q", fx_q, 0);
    rst = 1'b0;
    read_check("por_stat", REG_STAT, 8'h00);

    // single shot, all channels; a second SHOT mid-frame must be ignored
    fx_write(DEV, REG_CH_EN, 8'hFF);
    read_check("t2_chen", REG_CH_EN, 8'hFF);
    base  = vld_cnt;
    rbase = rise_cnt;
    fx_write(DEV, REG_CTRL, 8'h02);
    wait_cycles(10);
    read_check("t2_busy", REG_STAT, 8'h01);
    fx_write(DEV, REG_CTRL, 8'h02);
    wait_vld("t2_timeout", base + 1, 400);
    wait_cycles(300);
    check("t2_vld_count", vld_cnt - base, 1);
    check("t2_vld_mask", last_vld, 8'hFF);
    check("t2_sclk_rises", rise_cnt - rbase, 16);
    for (int k = 0; k < 8; k++) exp_data[k*16 +: 16] = 16'hA5A0 + 16'(k);
    check("t2_data", ad_data, exp_data);
    read_check("t2_ctrl_selfclr", REG_CTRL, 8'h00);
    read_check("t2_idle", REG_STAT, 8'h00);

    // asynchronous reset in the middle of a shift
    fx_write(DEV, REG_PER_L, 8'h34);
    fx_write(DEV, REG_CTRL, 8'h02);
    begin
      int n = 0;
      while (cs_n && n < 50) begin
        @(negedge clk_sys);
        n++;
      end
    end
    check("t1_cs_low", cs_n, 0);
    wait_cycles(40);
    #2 rst = 1'b1;
    #1;
    check("t1_cs_n", cs_n, 1);
    check("t1_sclk", sclk, 1);
    check("t1_vld", ad_vld, 0);
    check("t1_data", ad_data, 0);
    wait_cycles(2);
    rst = 1'b0;
    read_check("t1_ctrl", REG_CTRL, 8'h00);
    read_check("t1_chen", REG_CH_EN, 8'h00);
    read_check("t1_perl", REG_PER_L, 8'h00);
    read_check("t1_stat", REG_STAT, 8'h00);
    read_check("t1_d0lo", 8'h10, 8'h00);

    // periodic conversions every 50 us
    fx_write(DEV, REG_CH_EN, 8'hFF);
    fx_write(DEV, REG_PER_L, 8'd50);
    fx_write(DEV, REG_PER_H, 8'h00);
    read_check("t3_perl", REG_PER_L, 8'd50);
    read_check("t3_perh", REG_PER_H, 8'h00);
    base = vld_cnt;
    fx_write(DEV, REG_CTRL, 8'h01);
    read_check("t3_run", REG_CTRL, 8'h01);
    wait_vld("t3_timeout", base + 6, 35000);
    for (int i = 1; i < 6; i++)
      check($sformatf("t3_interval%0d", i), vld_t[base + i] - vld_t[base + i - 1], 5000);
    fx_write(DEV, REG_CTRL, 8'h00);
    wait_cycles(300);
    read_check("t3_stat", REG_STAT, 8'h00);

    // overrun with a 1 us period
    fx_write(DEV, REG_PER_L, 8'd1);
    base = vld_cnt;
    fx_write(DEV, REG_CTRL, 8'h01);
    wait_cycles(2000);
    check("t4_rate", (vld_cnt - base) >= 8, 1);
    fx_read(DEV, REG_STAT, rq);
    check("t4_ovr_set", rq[1], 1);
    fx_write(DEV, REG_CTRL, 8'h00);
    wait_cycles(300);
    read_check("t4_ovr_sticky", REG_STAT, 8'h02);
    fx_write(DEV, REG_CTRL, 8'h04);
    read_check("t4_ovr_clr", REG_STAT, 8'h00);
    fx_write(DEV, REG_CTRL, 8'h01);
    wait_cycles(500);
    fx_write(DEV, REG_CTRL, 8'h00);
    wait_cycles(300);
    read_check("t4_ovr_again", REG_STAT, 8'h02);

    // channel mask: only ch0 and ch2 update
    for (int k = 0; k < 8; k++) adc_word[k] = 16'h3C30 + 16'(k);
    fx_write(DEV, REG_CH_EN, 8'h05);
    base = vld_cnt;
    fx_write(DEV, REG_CTRL, 8'h02);
    wait_vld("t5_timeout", base + 1, 400);
    wait_cycles(200);
    check("t5_vld_count", vld_cnt - base, 1);
    check("t5_vld_mask", last_vld, 8'h05);
    for (int k = 0; k < 8; k++)
      exp_data[k*16 +: 16] = (k == 0 || k == 2) ? 16'h3C30 + 16'(k) : 16'hA5A0 + 16'(k);
    check("t5_data", ad_data, exp_data);

    // lo/hi coherence, foreign device id, unmapped addresses
    read_check("t6_lo_old", 8'h10, 8'h30);
    adc_word[0] = 16'h7788;
    base = vld_cnt;
    fx_write(DEV, REG_CTRL, 8'h02);
    wait_vld("t6_timeout", base + 1, 400);
    wait_cycles(20);
    check("t6_ch0_new", ad_data[15:0], 16'h7788);
    read_check("t6_hi_shadow", 8'h11, 8'h3C);
    read_check("t6_lo_new", 8'h10, 8'h88);
    read_check("t6_hi_new", 8'h11, 8'h77);
    read_check("t6_ch2_lo", 8'h14, 8'h32);
    fx_read(FOREIGN, 8'h10, rq);
    check("t6_foreign_rd", rq, 8'h00);
    read_check("t6_unmapped_05", 8'h05, 8'h00);
    read_check("t6_unmapped_20", 8'h20, 8'h00);
    fx_write(FOREIGN, REG_CH_EN, 8'hAA);
    read_check("t6_foreign_wr", REG_CH_EN, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
